// File: rtl/seq_mul_operand_gen_if.sv
// Operand-generator handshake bundle: job input (X, Y, C) and the adder-facing
// operand output (A = X*Y, B = C), plus the busy status.
interface seq_mul_operand_gen_if #(
    parameter int XW = 26,
    parameter int YW = 15,
    parameter int CW = 15
);
    localparam int PW = XW + YW;

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic [CW-1:0] in_c;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] op_a;
    logic [CW-1:0] op_b;
    logic          busy;

    // master: job source and adder stage; slave: the multiplier block
    modport master (
        output in_valid, in_x, in_y, in_c, out_ready,
        input  in_ready, out_valid, op_a, op_b, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_c, out_ready,
        output in_ready, out_valid, op_a, op_b, busy
    );
endinterface

// File: rtl/seq_mul_operand_gen.sv
// Iterative shift-add multiplier feeding the 41+15-bit adder with A = X*Y, B = C.
// Optional SEQ_MUL_EARLY_TERM_EN ends the MUL phase once no multiplier bits remain.
//
// state | meaning
// IDLE  | ready for a new job (in_ready=1)
// MUL   | one multiplier bit per cycle, shift-add into acc
// OUT   | op_a/op_b presented with out_valid until the adder consumes them
module seq_mul_operand_gen #(
    parameter int XW = 26,
    parameter int YW = 15,
    parameter int CW = 15
) (
    input logic clk,
    input logic rst_n,
    seq_mul_operand_gen_if.slave bus
);
    localparam int PW   = XW + YW;
    localparam int CNTW = (YW > 1) ? $clog2(YW) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(YW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   x_sh;
    logic [YW-1:0]   y_sh;
    logic [CW-1:0]   c_reg;
    logic [CNTW-1:0] cnt;
    logic            mul_done;

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign mul_done = (cnt == LAST) || ((y_sh >> 1) == '0);
`else
    assign mul_done = (cnt == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = MUL;
            MUL:     if (mul_done)      state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            x_sh  <= '0;
            y_sh  <= '0;
            c_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_sh  <= {{YW{1'b0}}, bus.in_x};
                        y_sh  <= bus.in_y;
                        c_reg <= bus.in_c;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    // acc cannot overflow: the final sum is bounded by X*Y < 2**PW
                    if (y_sh[0]) acc <= acc + x_sh;
                    x_sh <= x_sh << 1;
                    y_sh <= y_sh >> 1;
                    cnt  <= cnt + CNTW'(1);
                end
                default: ;
            endcase
        end
    end

    // op_a/op_b come straight from registers; acc is frozen in OUT and IDLE
    assign bus.op_a      = acc;
    assign bus.op_b      = c_reg;
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_seq_mul_operand_gen.sv
// Directed-vector bench for seq_mul_operand_gen: latency, products, backpressure,
// reset abort and ignored in_valid while busy.
module tb_seq_mul_operand_gen;
    localparam int XW = 26;
    localparam int YW = 15;
    localparam int CW = 15;
    localparam int PW = XW + YW;
    localparam int TIMEOUT = 200;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    seq_mul_operand_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

    seq_mul_operand_gen #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int exp_lat(input logic [YW-1:0] y);
`ifdef SEQ_MUL_EARLY_TERM_EN
        int l;
        l = 1;
        for (int i = 0; i < YW; i++) if (y[i]) l = i + 1;
        return l;
`else
        return YW;
`endif
    endfunction

    // Accepts one job, optionally pulses in_valid with X=99 during MUL, waits for
    // out_valid, then checks latency and operands; leaves the block in OUT.
    task automatic run_job(input string tag, input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic [CW-1:0] c, input logic [PW-1:0] exp_a, input bit pulse);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_c     = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < TIMEOUT) begin
            if (pulse && lat == 3) begin
                bus.in_valid = 1'b1;
                bus.in_x     = 26'd99;
            end
            if (pulse && lat == 6) begin
                bus.in_valid = 1'b0;
                bus.in_x     = x;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat(y)));
        chk({tag, ".op_a"}, 64'(bus.op_a), 64'(exp_a));
        chk({tag, ".op_b"}, 64'(bus.op_b), 64'(c));
        chk({tag, ".in_ready_out"}, 64'(bus.in_ready), 64'd0);
        chk({tag, ".busy_out"}, 64'(bus.busy), 64'd1);
    endtask

    // Completes the pending output handshake and checks the return to IDLE.
    task automatic finish_job(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst.busy",      64'(bus.busy),      64'd0);
        chk("rst.op_a",      64'(bus.op_a),      64'd0);
        chk("rst.op_b",      64'(bus.op_b),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job("basic", 26'd3, 15'd5, 15'd7, 41'd15, 1'b0);
        finish_job("basic");

        run_job("max", 26'h3FFFFFF, 15'h7FFF, 15'h7FFF, 41'h1FFFBFF8001, 1'b0);
        finish_job("max");

        bus.out_ready = 1'b0;
        run_job("bp", 26'd10, 15'd10, 15'd1, 41'd100, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp.hold_op_a",  64'(bus.op_a),      64'd100);
            chk("bp.hold_ready", 64'(bus.in_ready),  64'd0);
        end
        finish_job("bp");
        @(posedge clk);
        #1;
        chk("bp.single_hs", 64'(bus.out_valid), 64'd0);

        // abort a 10*10 job after six MUL cycles (acc already holds 20+80)
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 26'd10;
        bus.in_y     = 15'd10;
        bus.in_c     = 15'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort.op_a",      64'(bus.op_a),      64'd0);
        chk("abort.op_b",      64'(bus.op_b),      64'd0);
        chk("abort.in_ready",  64'(bus.in_ready),  64'd1);
        chk("abort.busy",      64'(bus.busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job("post_abort", 26'd2, 15'd3, 15'd4, 41'd6, 1'b0);
        finish_job("post_abort");

        run_job("pulse", 26'd7, 15'd9, 15'd2, 41'd63, 1'b1);
        finish_job("pulse");

        run_job("y1", 26'h123, 15'd1, 15'd0, 41'h123, 1'b0);
        finish_job("y1");
        run_job("ymsb", 26'd5, 15'h4000, 15'd9, 41'h14000, 1'b0);
        finish_job("ymsb");
        run_job("y0", 26'h55, 15'd0, 15'd1, 41'd0, 1'b0);
        finish_job("y0");
        run_job("x0", 26'd0, 15'h1234, 15'h6, 41'd0, 1'b0);
        finish_job("x0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
